// File: rtl/alu_pkg.sv
// Shared types and constants for the arbitrated add-with-flags datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FLAG_W    = 5;
  localparam int FLG_SIGN  = 4;
  localparam int FLG_ZERO  = 3;
  localparam int FLG_CARRY = 2;
  localparam int FLG_PAR   = 1;
  localparam int FLG_OVF   = 0;

endpackage

// File: rtl/alu_add_flags.sv
// Combinational WIDTH-bit adder producing the sum and its five status flags.
module alu_add_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  z,
  output logic [FLAG_W-1:0] flags
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, x} + {1'b0, y};
    z     = sum[WIDTH-1:0];
    flags = '0;
    flags[FLG_SIGN]  = sum[WIDTH-1];
    flags[FLG_ZERO]  = (sum[WIDTH-1:0] == '0);
    flags[FLG_CARRY] = sum[WIDTH];
    // Parity is set for an even number of ones in the sum.
    flags[FLG_PAR]   = ~^sum[WIDTH-1:0];
    flags[FLG_OVF]   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/alu_add_arbiter.sv
// Round-robin arbiter sharing one adder between two requesters via IDLE/EXEC/RESP.
module alu_add_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_x,
  input  logic [WIDTH-1:0]  req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_x,
  input  logic [WIDTH-1:0]  req1_y,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_z,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy
);

  state_t             state;
  logic               rr_ptr;
  logic               owner;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   sum_z;
  logic [FLAG_W-1:0]  sum_flags;
  logic               grant0;
  logic               grant1;
  logic               owner_ready;

  alu_add_flags #(.WIDTH(WIDTH)) u_add (
    .x     (x_q),
    .y     (y_q),
    .z     (sum_z),
    .flags (sum_flags)
  );

  // A lone requester always wins; on contention rr_ptr picks the winner.
  always_comb begin
    grant0 = !rst && (state == IDLE) && req0_valid && (!req1_valid || !rr_ptr);
    grant1 = !rst && (state == IDLE) && req1_valid && (!req0_valid ||  rr_ptr);
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) &&  owner;
  assign busy        = (state != IDLE);
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            x_q   <= grant1 ? req1_x : req0_x;
            y_q   <= grant1 ? req1_y : req0_y;
            owner <= grant1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_z     <= sum_z;
          rsp_flags <= sum_flags;
          state     <= RESP;
        end
        RESP: begin
          // Handing priority to the other side keeps a busy requester from starving it.
          if (owner_ready) begin
            rr_ptr <= ~owner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_add_arbiter.sv
// Directed self-checking bench for alu_add_arbiter with hand-computed results.
module tb_alu_add_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_z;
  logic [4:0]       rsp_flags;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Handshake/status snapshot: {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}
  wire [4:0] ctl = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy};

  alu_add_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_z      (rsp_z),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    step();
    tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL reset_ctl got=%b exp=%b", ctl, 5'b00000); end
    tests_run++; if (rsp_z !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_z got=%h exp=%h", rsp_z, 16'h0000); end
    tests_run++; if (rsp_flags !== 5'b00000) begin tests_failed++; $display("[TB] FAIL reset_flags got=%b exp=%b", rsp_flags, 5'b00000); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    step();
    tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL reset_idle_ctl got=%b exp=%b", ctl, 5'b00000); end
  endtask

  task automatic test_overflow_sign;
    req0_x = 16'h7FFF; req0_y = 16'h0001; req0_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b10000) begin tests_failed++; $display("[TB] FAIL ovf_accept got=%b exp=%b", ctl, 5'b10000); end
    step();
    req0_valid = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL ovf_exec got=%b exp=%b", ctl, 5'b00001); end
    step();
    tests_run++; if (ctl !== 5'b00101) begin tests_failed++; $display("[TB] FAIL ovf_resp got=%b exp=%b", ctl, 5'b00101); end
    tests_run++; if (rsp_z !== 16'h8000) begin tests_failed++; $display("[TB] FAIL ovf_z got=%h exp=%h", rsp_z, 16'h8000); end
    tests_run++; if (rsp_flags !== 5'b10001) begin tests_failed++; $display("[TB] FAIL ovf_flags got=%b exp=%b", rsp_flags, 5'b10001); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL ovf_done got=%b exp=%b", ctl, 5'b00000); end
  endtask

  task automatic test_carry_zero;
    req1_x = 16'hFFFF; req1_y = 16'h0001; req1_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b01000) begin tests_failed++; $display("[TB] FAIL cz_accept got=%b exp=%b", ctl, 5'b01000); end
    step();
    req1_valid = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL cz_exec got=%b exp=%b", ctl, 5'b00001); end
    step();
    tests_run++; if (ctl !== 5'b00011) begin tests_failed++; $display("[TB] FAIL cz_resp got=%b exp=%b", ctl, 5'b00011); end
    tests_run++; if (rsp_z !== 16'h0000) begin tests_failed++; $display("[TB] FAIL cz_z got=%h exp=%h", rsp_z, 16'h0000); end
    tests_run++; if (rsp_flags !== 5'b01110) begin tests_failed++; $display("[TB] FAIL cz_flags got=%b exp=%b", rsp_flags, 5'b01110); end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL cz_done got=%b exp=%b", ctl, 5'b00000); end
  endtask

  task automatic test_simultaneous;
    req0_x = 16'h0003; req0_y = 16'h0004; req0_valid = 1'b1;
    req1_x = 16'h0010; req1_y = 16'h0020; req1_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b10000) begin tests_failed++; $display("[TB] FAIL sim_first got=%b exp=%b", ctl, 5'b10000); end
    step();
    req0_valid = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL sim_exec0 got=%b exp=%b", ctl, 5'b00001); end
    step();
    tests_run++; if (ctl !== 5'b00101) begin tests_failed++; $display("[TB] FAIL sim_resp0 got=%b exp=%b", ctl, 5'b00101); end
    tests_run++; if (rsp_z !== 16'h0007) begin tests_failed++; $display("[TB] FAIL sim_z0 got=%h exp=%h", rsp_z, 16'h0007); end
    tests_run++; if (rsp_flags !== 5'b00000) begin tests_failed++; $display("[TB] FAIL sim_flags0 got=%b exp=%b", rsp_flags, 5'b00000); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b01000) begin tests_failed++; $display("[TB] FAIL sim_second got=%b exp=%b", ctl, 5'b01000); end
    step();
    req1_valid = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL sim_exec1 got=%b exp=%b", ctl, 5'b00001); end
    step();
    tests_run++; if (ctl !== 5'b00011) begin tests_failed++; $display("[TB] FAIL sim_resp1 got=%b exp=%b", ctl, 5'b00011); end
    tests_run++; if (rsp_z !== 16'h0030) begin tests_failed++; $display("[TB] FAIL sim_z1 got=%h exp=%h", rsp_z, 16'h0030); end
    tests_run++; if (rsp_flags !== 5'b00010) begin tests_failed++; $display("[TB] FAIL sim_flags1 got=%b exp=%b", rsp_flags, 5'b00010); end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back;
    req0_x = 16'h0005; req0_y = 16'h0005; req0_valid = 1'b1;
    req1_x = 16'h8000; req1_y = 16'h8000; req1_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b10000) begin tests_failed++; $display("[TB] FAIL b2b_pair_first got=%b exp=%b", ctl, 5'b10000); end
    step();
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL b2b_exec0 got=%b exp=%b", ctl, 5'b00001); end
    step();
    tests_run++; if (rsp_z !== 16'h000A) begin tests_failed++; $display("[TB] FAIL b2b_z0 got=%h exp=%h", rsp_z, 16'h000A); end
    tests_run++; if (rsp_flags !== 5'b00010) begin tests_failed++; $display("[TB] FAIL b2b_flags0 got=%b exp=%b", rsp_flags, 5'b00010); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b01000) begin tests_failed++; $display("[TB] FAIL b2b_waiter_wins got=%b exp=%b", ctl, 5'b01000); end
    step();
    req1_valid = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL b2b_exec1 got=%b exp=%b", ctl, 5'b00001); end
    step();
    tests_run++; if (ctl !== 5'b00011) begin tests_failed++; $display("[TB] FAIL b2b_resp1 got=%b exp=%b", ctl, 5'b00011); end
    tests_run++; if (rsp_z !== 16'h0000) begin tests_failed++; $display("[TB] FAIL b2b_z1 got=%h exp=%h", rsp_z, 16'h0000); end
    tests_run++; if (rsp_flags !== 5'b01111) begin tests_failed++; $display("[TB] FAIL b2b_flags1 got=%b exp=%b", rsp_flags, 5'b01111); end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b10000) begin tests_failed++; $display("[TB] FAIL b2b_held_req got=%b exp=%b", ctl, 5'b10000); end
    step();
    req0_valid = 1'b0;
    step();
    tests_run++; if (ctl !== 5'b00101) begin tests_failed++; $display("[TB] FAIL b2b_resp2 got=%b exp=%b", ctl, 5'b00101); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    #1;
  endtask

  task automatic test_backpressure;
    req0_x = 16'h1234; req0_y = 16'h1111; req0_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b10000) begin tests_failed++; $display("[TB] FAIL bp_accept got=%b exp=%b", ctl, 5'b10000); end
    step();
    req0_valid = 1'b0;
    req1_x = 16'h0100; req1_y = 16'h0200; req1_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL bp_exec got=%b exp=%b", ctl, 5'b00001); end
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (ctl !== 5'b00101) begin tests_failed++; $display("[TB] FAIL bp_hold_ctl[%0d] got=%b exp=%b", i, ctl, 5'b00101); end
      tests_run++; if (rsp_z !== 16'h2345) begin tests_failed++; $display("[TB] FAIL bp_hold_z[%0d] got=%h exp=%h", i, rsp_z, 16'h2345); end
      tests_run++; if (rsp_flags !== 5'b00010) begin tests_failed++; $display("[TB] FAIL bp_hold_flags[%0d] got=%b exp=%b", i, rsp_flags, 5'b00010); end
      step();
    end
    rsp0_ready = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b00101) begin tests_failed++; $display("[TB] FAIL bp_handshake got=%b exp=%b", ctl, 5'b00101); end
    step();
    rsp0_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b01000) begin tests_failed++; $display("[TB] FAIL bp_waiter_accept got=%b exp=%b", ctl, 5'b01000); end
    step();
    req1_valid = 1'b0;
    step();
    tests_run++; if (ctl !== 5'b00011) begin tests_failed++; $display("[TB] FAIL bp_resp1 got=%b exp=%b", ctl, 5'b00011); end
    tests_run++; if (rsp_z !== 16'h0300) begin tests_failed++; $display("[TB] FAIL bp_z1 got=%h exp=%h", rsp_z, 16'h0300); end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid;
    // req0 completes first so the pointer favours req1 before the abort
    req0_x = 16'h0001; req0_y = 16'h0001; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    tests_run++; if (rsp_z !== 16'h0002) begin tests_failed++; $display("[TB] FAIL rm_pre_z got=%h exp=%h", rsp_z, 16'h0002); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    req1_x = 16'h00FF; req1_y = 16'h0001; req1_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b01000) begin tests_failed++; $display("[TB] FAIL rm_accept1 got=%b exp=%b", ctl, 5'b01000); end
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b00001) begin tests_failed++; $display("[TB] FAIL rm_in_exec got=%b exp=%b", ctl, 5'b00001); end
    step();
    rst = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL rm_aborted got=%b exp=%b", ctl, 5'b00000); end
    tests_run++; if (rsp_z !== 16'h0000) begin tests_failed++; $display("[TB] FAIL rm_z got=%h exp=%h", rsp_z, 16'h0000); end
    tests_run++; if (rsp_flags !== 5'b00000) begin tests_failed++; $display("[TB] FAIL rm_flags got=%b exp=%b", rsp_flags, 5'b00000); end
    step();
    tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL rm_no_resp got=%b exp=%b", ctl, 5'b00000); end
    req0_x = 16'h0003; req0_y = 16'h0004; req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    tests_run++; if (ctl !== 5'b10000) begin tests_failed++; $display("[TB] FAIL rm_ptr_reset got=%b exp=%b", ctl, 5'b10000); end
    step();
    req0_valid = 1'b0;
    step();
    tests_run++; if (rsp_z !== 16'h0007) begin tests_failed++; $display("[TB] FAIL rm_z0 got=%h exp=%h", rsp_z, 16'h0007); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    #1;
    tests_run++; if (ctl !== 5'b01000) begin tests_failed++; $display("[TB] FAIL rm_accept_after got=%b exp=%b", ctl, 5'b01000); end
    step();
    req1_valid = 1'b0;
    step();
    tests_run++; if (ctl !== 5'b00011) begin tests_failed++; $display("[TB] FAIL rm_resp1 got=%b exp=%b", ctl, 5'b00011); end
    tests_run++; if (rsp_z !== 16'h0100) begin tests_failed++; $display("[TB] FAIL rm_z1 got=%h exp=%h", rsp_z, 16'h0100); end
    tests_run++; if (rsp_flags !== 5'b00000) begin tests_failed++; $display("[TB] FAIL rm_flags1 got=%b exp=%b", rsp_flags, 5'b00000); end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
  endtask

  task automatic test_idle_hold;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++; if (ctl !== 5'b00000) begin tests_failed++; $display("[TB] FAIL idle_hold[%0d] got=%b exp=%b", i, ctl, 5'b00000); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    test_reset();
    test_overflow_sign();
    test_carry_zero();
    test_simultaneous();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_idle_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
